// File: rtl/din_debounce_edge.sv
// din_debounce_edge
//
// Conditions a raw asynchronous 1-bit input before it feeds the D input of
// the downstream DFF stage. It works in three steps:
//   1. A two-flop synchroniser brings din into the clk domain (s1 -> s2).
//   2. A level change is accepted only after STABLE_CYCLES consecutive enabled
//      samples at the new level. Shorter pulses are rejected.
//   3. It produces a registered clean level plus one-cycle rise/fall strobes.
//
// Parameters:
//   STABLE_CYCLES : consecutive enabled samples needed to commit (1..2^CNT_W-1)
//   CNT_W         : width of the qualification counter
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   din  : raw asynchronous input
//   en   : sample enable; 0 freezes qualification (state, cnt, dout hold)
//   dout : debounced level, registered
//   rise : one-cycle pulse on dout 0->1, registered
//   fall : one-cycle pulse on dout 1->0, registered
//   busy : high while a level change is being qualified
//
// state     | meaning
// ----------+---------------------------------------------------------
// STABLE_LO | dout = 0, no change pending
// PEND_HI   | dout = 0, counting consecutive high samples of s2
// STABLE_HI | dout = 1, no change pending
// PEND_LO   | dout = 1, counting consecutive low samples of s2

module din_debounce_edge #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // With a one-sample window the first new-level sample commits directly,
    // so the PEND states are never entered.
    localparam bit SINGLE = (STABLE_CYCLES == 1);

    logic             s1, s2;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dout_nxt, rise_nxt, fall_nxt;

    // The synchroniser runs regardless of en so s2 always reflects din.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STABLE_LO;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dout  <= dout_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (en) begin
            case (state)
                STABLE_LO: begin
                    if (s2) begin
                        if (SINGLE) begin
                            state_nxt = STABLE_HI;
                            dout_nxt  = 1'b1;
                            rise_nxt  = 1'b1;
                        end else begin
                            state_nxt = PEND_HI;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                PEND_HI: begin
                    if (!s2) begin
                        state_nxt = STABLE_LO;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_HI;
                        dout_nxt  = 1'b1;
                        rise_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s2) begin
                        if (SINGLE) begin
                            state_nxt = STABLE_LO;
                            dout_nxt  = 1'b0;
                            fall_nxt  = 1'b1;
                        end else begin
                            state_nxt = PEND_LO;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                PEND_LO: begin
                    if (s2) begin
                        state_nxt = STABLE_HI;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_LO;
                        dout_nxt  = 1'b0;
                        fall_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign busy = (state == PEND_HI) || (state == PEND_LO);

endmodule
